// File: rtl/fetch_pkg.sv
// Shared types and constants for the streaming fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    localparam int unsigned INSN_BYTES   = 4;
    localparam int unsigned FETCH_AWIDTH = 32;
    localparam int unsigned FETCH_DWIDTH = 32;

    // One decoded-side queue entry: fetch PC and the instruction word returned for it.
    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; combinational read of the head entry.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins; overflow pushes and underflow pops are ignored.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer and count update.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_stream.sv
// Decoupled fetch stage: credit-limited request issue, in-order responses, redirect flush.
module fetch_stream
    import fetch_pkg::*;
#(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_i,
    input  logic [AWIDTH-1:0]        redirect_pc_i,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [AWIDTH-1:0]        mem_req_addr_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [DWIDTH-1:0]        mem_rsp_data_i,
    output logic                     insn_valid_o,
    input  logic                     insn_ready_i,
    output logic [AWIDTH-1:0]        pc_o,
    output logic [DWIDTH-1:0]        insn_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = AWIDTH + DWIDTH;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW-1:0]     occupancy;
    logic [CW:0]       credit_used;
    logic              req_valid;
    logic              req_fire;
    logic              rsp_fire;
    logic              rsp_push;
    logic              head_pop;
    logic              q_empty;
    logic              q_full;
    logic [EW-1:0]     head;
    logic [AWIDTH-1:0] rsp_pc;
    logic [CW-1:0]     tag_count;
    logic              tag_empty;
    logic              tag_full;

    // Handshake qualifiers; redirect masks issue, drops responses and cancels pops.
    assign credit_used = (CW+1)'(occupancy) + (CW+1)'(inflight_q);
    assign req_valid   = (state_q == S_FETCH) && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign req_fire    = req_valid && mem_req_ready_i;
    assign rsp_fire    = mem_rsp_valid_i && (inflight_q != '0);
    assign rsp_push    = rsp_fire && (discard_q == '0) && !redirect_i;
    assign head_pop    = !q_empty && insn_ready_i && !redirect_i;

    // PC tags of outstanding requests, popped by every response (kept or dropped).
    fetch_fifo #(.WIDTH(AWIDTH), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_fire),
        .flush (1'b0),
        .wdata (fetch_pc_q),
        .rdata (rsp_pc),
        .count (tag_count),
        .empty (tag_empty),
        .full  (tag_full)
    );

    // Instruction queue feeding decode; cleared on redirect.
    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_insn_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .pop   (head_pop),
        .flush (redirect_i),
        .wdata ({rsp_pc, mem_rsp_data_i}),
        .rdata (head),
        .count (occupancy),
        .empty (q_empty),
        .full  (q_full)
    );

    // State, PC and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= BASE_ADDR;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state: redirect turns everything still in flight into responses to discard.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);

        if (redirect_i) begin
            discard_d  = inflight_d;
            fetch_pc_d = redirect_pc_i & ~AWIDTH'(INSN_BYTES - 1);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + AWIDTH'(INSN_BYTES);
            if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end

        if (state_q == S_IDLE) state_d = S_FETCH;
        else                   state_d = (discard_d != '0) ? S_FLUSH : S_FETCH;
    end

    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = fetch_pc_q;
    assign insn_valid_o    = !q_empty;
    assign pc_o            = q_empty ? '0 : head[EW-1:DWIDTH];
    assign insn_o          = q_empty ? '0 : head[DWIDTH-1:0];
    assign occupancy_o     = occupancy;

    // Protocol and credit invariants.
    a_rsp_legal: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rsp_valid_i && (inflight_q == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_push && q_full) && !(req_fire && tag_full) && !(rsp_fire && tag_empty));
    a_tags_track: assert property (@(posedge clk) disable iff (!rst)
        tag_count == inflight_q);

endmodule

// File: tb/tb_fetch_stream.sv
// Self-checking bench for fetch_stream: memory responder plus epoch-based reference model.
module tb_fetch_stream;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic        insn_valid_o;
    logic        insn_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [2:0]  occupancy_o;

    fetch_stream #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .insn_valid_o    (insn_valid_o),
        .insn_ready_i    (insn_ready_i),
        .pc_o            (pc_o),
        .insn_o          (insn_o),
        .occupancy_o     (occupancy_o)
    );

    always #5 clk = ~clk;

    // Reference model state: outstanding requests tagged with the redirect epoch that issued them.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t         pend[$];
    fetch_entry_t expq[$];
    logic [31:0]  mpc    = BASE;
    int           epoch  = 0;
    bit           idle_m = 1'b1;
    int           cyc    = 0;
    int           lat    = 1;
    int           n_cmp  = 0;
    int           n_err  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) n++;
        return n;
    endfunction

    // Requests allowed only outside the post-reset cycle, with no stale responses left and free credit.
    function automatic bit model_req_valid();
        return !idle_m && !redirect_i && (stale_cnt() == 0) &&
               ((expq.size() + pend.size()) < int'(DEPTH));
    endfunction

    // Model update at each edge, then drive the in-order memory response for the new cycle.
    always begin
        req_t r;
        bit   fire;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            pend.delete();
            expq.delete();
            mpc    = BASE;
            epoch  = 0;
            idle_m = 1'b1;
        end else begin
            fire = model_req_valid() && mem_req_ready_i;
            if ((expq.size() > 0) && insn_ready_i && !redirect_i) void'(expq.pop_front());
            if (mem_rsp_valid_i && (pend.size() > 0)) begin
                r = pend.pop_front();
                if ((r.epoch == epoch) && !redirect_i)
                    expq.push_back('{pc: r.addr, insn: mem_word(r.addr)});
            end
            if (fire) begin
                pend.push_back('{addr: mpc, epoch: epoch, due: cyc + lat - 1});
                mpc = mpc + 32'd4;
            end
            if (redirect_i) begin
                expq.delete();
                epoch++;
                mpc = {redirect_pc_i[31:2], 2'b00};
            end
            idle_m = 1'b0;
        end
        #1;
        if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(pend[0].addr);
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = '0;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        mem_req_ready_i = 1'b0; insn_ready_i = 1'b0; lat = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_idle_req_valid: got %b expected 0", mem_req_valid_o); end
        n_cmp++; if (insn_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_insn_valid: got %b expected 0", insn_valid_o); end
        n_cmp++; if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy_o); end
        n_cmp++; if ((pc_o !== 32'h0) || (insn_o !== 32'h0)) begin n_err++; $display("FAIL reset_head: got pc %h insn %h expected 0/0", pc_o, insn_o); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if ((mem_req_valid_o !== 1'b1) || (mem_req_addr_o !== BASE)) begin
                n_err++; $display("FAIL reset_first_req c%0d: got valid %b addr %h expected 1 %h", c, mem_req_valid_o, mem_req_addr_o, BASE);
            end
            n_cmp++; if (insn_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_no_insn c%0d: got %b expected 0", c, insn_valid_o); end
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc = BASE;
        int late = 0;
        do_reset();
        @(posedge clk);
        #1 mem_req_ready_i = 1'b1; insn_ready_i = 1'b1; lat = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++; if (mem_req_valid_o !== model_req_valid()) begin n_err++; $display("FAIL stream_req_valid c%0d: got %b expected %b", c, mem_req_valid_o, model_req_valid()); end
            if (insn_valid_o && insn_ready_i) begin
                n_cmp++; if ((pc_o !== exp_pc) || (insn_o !== mem_word(exp_pc))) begin
                    n_err++; $display("FAIL stream_data c%0d: got pc %h insn %h expected %h %h", c, pc_o, insn_o, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                if (c >= 8) late++;
            end
        end
        n_cmp++; if (late !== 32) begin n_err++; $display("FAIL stream_throughput: got %0d insns in 32 cycles expected 32", late); end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        logic [31:0] e;
        do_reset();
        @(posedge clk);
        #1 mem_req_ready_i = 1'b1; insn_ready_i = 1'b0; lat = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req_valid_o && mem_req_ready_i) fires++;
        end
        n_cmp++; if (fires !== 4) begin n_err++; $display("FAIL bp_fires: got %0d expected 4", fires); end
        n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_req_stalled: got %b expected 0", mem_req_valid_o); end
        n_cmp++; if (occupancy_o !== 3'd4) begin n_err++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy_o); end
        @(posedge clk);
        #1 insn_ready_i = 1'b1; mem_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = BASE + 32'(4 * k);
            n_cmp++; if ((insn_valid_o !== 1'b1) || (pc_o !== e) || (insn_o !== mem_word(e))) begin
                n_err++; $display("FAIL bp_drain k%0d: got v%b pc %h insn %h expected 1 %h %h", k, insn_valid_o, pc_o, insn_o, e, mem_word(e));
            end
        end
        @(negedge clk);
        n_cmp++; if ((occupancy_o !== 3'd0) || (insn_valid_o !== 1'b0) || (mem_req_valid_o !== 1'b1)) begin
            n_err++; $display("FAIL bp_empty: got occ %0d v%b req %b expected 0 0 1", occupancy_o, insn_valid_o, mem_req_valid_o);
        end
    endtask

    task automatic test_redirect_flush();
        bit found = 1'b0;
        bit resumed = 1'b0;
        bit got = 1'b0;
        int drops = 0;
        do_reset();
        @(posedge clk);
        #1 mem_req_ready_i = 1'b1; insn_ready_i = 1'b1; lat = 5;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (pend.size() == 3) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL rf_setup: got no cycle with 3 in flight expected one"); end
        redirect_i = 1'b1; redirect_pc_i = 32'h0100_0103;
        #1;
        n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL rf_masked: got %b expected 0", mem_req_valid_o); end
        @(posedge clk);
        #1 redirect_i = 1'b0;
        for (int c = 0; c < 30 && !resumed; c++) begin
            @(negedge clk);
            if (mem_req_valid_o) resumed = 1'b1;
            else begin
                if (mem_rsp_valid_i) drops++;
                n_cmp++; if ((insn_valid_o !== 1'b0) || (occupancy_o !== 3'd0)) begin
                    n_err++; $display("FAIL rf_queue_empty c%0d: got v%b occ %0d expected 0 0", c, insn_valid_o, occupancy_o);
                end
            end
        end
        n_cmp++; if (!resumed) begin n_err++; $display("FAIL rf_resume: got no request expected one after flush"); end
        n_cmp++; if (drops !== 3) begin n_err++; $display("FAIL rf_drops: got %0d expected 3", drops); end
        n_cmp++; if (mem_req_addr_o !== 32'h0100_0100) begin n_err++; $display("FAIL rf_target: got %h expected 01000100", mem_req_addr_o); end
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (insn_valid_o) begin
                got = 1'b1;
                n_cmp++; if ((pc_o !== 32'h0100_0100) || (insn_o !== mem_word(32'h0100_0100))) begin
                    n_err++; $display("FAIL rf_first_insn: got %h %h expected 01000100 %h", pc_o, insn_o, mem_word(32'h0100_0100));
                end
            end
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL rf_delivery: got no insn expected one"); end
    endtask

    task automatic test_same_cycle();
        bit found = 1'b0;
        bit resumed = 1'b0;
        bit got = 1'b0;
        int exp_disc = 0;
        int drops = 0;
        do_reset();
        @(posedge clk);
        #1 mem_req_ready_i = 1'b1; insn_ready_i = 1'b1; lat = 3;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (mem_rsp_valid_i && insn_valid_o && (pend.size() >= 2)) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL sc_setup: got no rsp+pop cycle expected one"); end
        exp_disc = pend.size() - 1;
        redirect_i = 1'b1; redirect_pc_i = 32'h0200_0042;
        #1;
        n_cmp++; if (mem_req_valid_o !== 1'b0) begin n_err++; $display("FAIL sc_masked: got %b expected 0", mem_req_valid_o); end
        @(posedge clk);
        #1 redirect_i = 1'b0;
        @(negedge clk);
        n_cmp++; if ((occupancy_o !== 3'd0) || (insn_valid_o !== 1'b0)) begin
            n_err++; $display("FAIL sc_cleared: got occ %0d v%b expected 0 0", occupancy_o, insn_valid_o);
        end
        for (int c = 0; c < 30 && !resumed; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_req_valid_o) resumed = 1'b1;
            else if (mem_rsp_valid_i) drops++;
        end
        n_cmp++; if (drops !== exp_disc) begin n_err++; $display("FAIL sc_discard: got %0d dropped expected %0d", drops, exp_disc); end
        n_cmp++; if (mem_req_addr_o !== 32'h0200_0040) begin n_err++; $display("FAIL sc_target: got %h expected 02000040", mem_req_addr_o); end
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (insn_valid_o) begin
                got = 1'b1;
                n_cmp++; if (pc_o !== 32'h0200_0040) begin n_err++; $display("FAIL sc_first_insn: got %h expected 02000040", pc_o); end
            end
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL sc_delivery: got no insn expected one"); end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[2];
        logic [31:0] dpcs[2];
        int na = 0;
        int nd = 0;
        do_reset();
        @(posedge clk);
        #1 mem_req_ready_i = 1'b1; insn_ready_i = 1'b1; lat = 1;
        repeat (4) @(posedge clk);
        #1 redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 redirect_i = 1'b0;
        for (int c = 0; c < 30 && (na < 2 || nd < 2); c++) begin
            @(negedge clk);
            if (mem_req_valid_o && mem_req_ready_i && (na < 2)) begin addrs[na] = mem_req_addr_o; na++; end
            if (insn_valid_o && insn_ready_i && (nd < 2)) begin dpcs[nd] = pc_o; nd++; end
        end
        n_cmp++; if ((na !== 2) || (addrs[0] !== 32'hFFFF_FFFC) || (addrs[1] !== 32'h0000_0000)) begin
            n_err++; $display("FAIL wrap_req: got n%0d %h %h expected 2 fffffffc 00000000", na, addrs[0], addrs[1]);
        end
        n_cmp++; if ((nd !== 2) || (dpcs[0] !== 32'hFFFF_FFFC) || (dpcs[1] !== 32'h0000_0000)) begin
            n_err++; $display("FAIL wrap_insn: got n%0d %h %h expected 2 fffffffc 00000000", nd, dpcs[0], dpcs[1]);
        end
    endtask

    task automatic test_random();
        bit ev;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            rst             = (c != 300);
            mem_req_ready_i = ($urandom_range(0, 3) != 0);
            insn_ready_i    = ($urandom_range(0, 2) != 0);
            lat             = int'($urandom_range(1, 6));
            redirect_i      = ($urandom_range(0, 24) == 0);
            redirect_pc_i   = $urandom();
            @(negedge clk);
            if (c == 0 || c == 301) continue;
            ev = model_req_valid();
            n_cmp++; if (mem_req_valid_o !== ev) begin n_err++; $display("FAIL rnd_req_valid c%0d: got %b expected %b", c, mem_req_valid_o, ev); end
            if (ev) begin
                n_cmp++; if (mem_req_addr_o !== mpc) begin n_err++; $display("FAIL rnd_req_addr c%0d: got %h expected %h", c, mem_req_addr_o, mpc); end
            end
            n_cmp++; if (occupancy_o !== 3'(expq.size())) begin n_err++; $display("FAIL rnd_occupancy c%0d: got %0d expected %0d", c, occupancy_o, expq.size()); end
            n_cmp++; if (insn_valid_o !== (expq.size() != 0)) begin n_err++; $display("FAIL rnd_insn_valid c%0d: got %b expected %b", c, insn_valid_o, expq.size() != 0); end
            if (expq.size() != 0) begin
                n_cmp++; if ((pc_o !== expq[0].pc) || (insn_o !== expq[0].insn)) begin
                    n_err++; $display("FAIL rnd_head c%0d: got %h %h expected %h %h", c, pc_o, insn_o, expq[0].pc, expq[0].insn);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_flush();
        test_same_cycle();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog");
    end

endmodule
